// File: rtl/tlc_pkg.sv
// Shared types and constants for the fixed-time traffic light controller.
// Holds the phase enum, lamp encodings and timer sizing helpers.
package tlc_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_2  = 3'd5
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: restarts at zero whenever the controller changes phase
// and flags the last cycle of the current phase.
module tlc_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_last,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == i_last);

endmodule

// File: rtl/traffic_light_controller.sv
// Fixed-time two-way intersection controller (Moore FSM).
// Phase order: NS green, NS yellow, all-red, EW green, EW yellow, all-red.
module traffic_light_controller
    import tlc_pkg::*;
#(
    parameter int GREEN_CYCLES  = 5,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] NS_light,
    output logic [2:0] EW_light
);

    localparam int MAXC = max3(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES);
    localparam int W    = cnt_width(MAXC);

    localparam logic [W-1:0] G_LAST = W'(GREEN_CYCLES - 1);
    localparam logic [W-1:0] Y_LAST = W'(YELLOW_CYCLES - 1);
    localparam logic [W-1:0] A_LAST = W'(ALLRED_CYCLES - 1);

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   w_last;
    logic           w_done;
    logic           w_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= NS_GREEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_last = '0;
        case (r_state)
            NS_GREEN: begin
                w_last = G_LAST;
                if (w_done) w_next = NS_YELLOW;
            end
            NS_YELLOW: begin
                w_last = Y_LAST;
                if (w_done) w_next = ALLRED_1;
            end
            ALLRED_1: begin
                w_last = A_LAST;
                if (w_done) w_next = EW_GREEN;
            end
            EW_GREEN: begin
                w_last = G_LAST;
                if (w_done) w_next = EW_YELLOW;
            end
            EW_YELLOW: begin
                w_last = Y_LAST;
                if (w_done) w_next = ALLRED_2;
            end
            ALLRED_2: begin
                w_last = A_LAST;
                if (w_done) w_next = NS_GREEN;
            end
            // Corrupted encodings recover through the clearance phase.
            default: w_next = ALLRED_2;
        endcase
    end

    // Every phase hands off to a different phase, so any change restarts the timer.
    assign w_load = (w_next != r_state);

    tlc_phase_timer #(
        .W(W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .i_load(w_load),
        .i_last(w_last),
        .o_done(w_done)
    );

    always_comb begin
        NS_light = RED;
        EW_light = RED;
        case (r_state)
            NS_GREEN:  NS_light = GREEN;
            NS_YELLOW: NS_light = YELLOW;
            EW_GREEN:  EW_light = GREEN;
            EW_YELLOW: EW_light = YELLOW;
            default: begin
                NS_light = RED;
                EW_light = RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for the traffic light controller: default timing,
// async reset, free run, minimum-length phases and illegal-state recovery.
module tb_traffic_light_controller;
    import tlc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [2:0] ns_a, ew_a;
    logic [2:0] ns_b, ew_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_light_controller dut (
        .clk     (clk),
        .reset   (rst_a),
        .NS_light(ns_a),
        .EW_light(ew_a)
    );

    traffic_light_controller #(
        .GREEN_CYCLES (1),
        .YELLOW_CYCLES(1),
        .ALLRED_CYCLES(1)
    ) dut_min (
        .clk     (clk),
        .reset   (rst_b),
        .NS_light(ns_b),
        .EW_light(ew_b)
    );

    // Hand-derived {NS,EW} for cycle k after release, default timing.
    function automatic logic [5:0] exp_def(input int k);
        int p;
        p = k % 16;
        if (p <= 4)  return {3'b001, 3'b100};
        if (p <= 6)  return {3'b010, 3'b100};
        if (p == 7)  return {3'b100, 3'b100};
        if (p <= 12) return {3'b100, 3'b001};
        if (p <= 14) return {3'b100, 3'b010};
        return {3'b100, 3'b100};
    endfunction

    function automatic logic [5:0] exp_min(input int k);
        case (k % 6)
            0:       return {3'b001, 3'b100};
            1:       return {3'b010, 3'b100};
            2:       return {3'b100, 3'b100};
            3:       return {3'b100, 3'b001};
            4:       return {3'b100, 3'b010};
            default: return {3'b100, 3'b100};
        endcase
    endfunction

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ns_a, ew_a} !== 6'b001_100) begin
            n_fail++;
            $display("FAIL reset_hold: got %b/%b expected 001/100", ns_a, ew_a);
        end
        n_checks++;
        if ({ns_b, ew_b} !== 6'b001_100) begin
            n_fail++;
            $display("FAIL reset_hold_min: got %b/%b expected 001/100", ns_b, ew_b);
        end
    endtask

    task automatic test_sequence();
        rst_a = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            n_checks++;
            if ({ns_a, ew_a} !== exp_def(k)) begin
                n_fail++;
                $display("FAIL seq cycle %0d: got %b/%b expected %b", k, ns_a, ew_a, exp_def(k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (9) @(negedge clk);
        n_checks++;
        if ({ns_a, ew_a} !== 6'b100_001) begin
            n_fail++;
            $display("FAIL mid_pre: got %b/%b expected 100/001", ns_a, ew_a);
        end
        #2 rst_a = 1'b0;
        #1;
        n_checks++;
        if ({ns_a, ew_a} !== 6'b001_100) begin
            n_fail++;
            $display("FAIL mid_async: got %b/%b expected 001/100", ns_a, ew_a);
        end
        @(negedge clk);
        rst_a = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            n_checks++;
            if ({ns_a, ew_a} !== exp_def(k)) begin
                n_fail++;
                $display("FAIL mid_restart cycle %0d: got %b/%b expected %b", k, ns_a, ew_a, exp_def(k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_freerun();
        int last_rise;
        logic prev_green;
        rst_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        last_rise = -1;
        prev_green = 1'b0;
        for (int k = 0; k < 200; k++) begin
            n_checks++;
            if (ns_a != 3'b100 && ew_a != 3'b100) begin
                n_fail++;
                $display("FAIL safety cycle %0d: got %b/%b", k, ns_a, ew_a);
            end
            n_checks++;
            if ($countones(ns_a) != 1 || $countones(ew_a) != 1) begin
                n_fail++;
                $display("FAIL onehot cycle %0d: got %b/%b", k, ns_a, ew_a);
            end
            n_checks++;
            if ({ns_a, ew_a} !== exp_def(k)) begin
                n_fail++;
                $display("FAIL free cycle %0d: got %b/%b expected %b", k, ns_a, ew_a, exp_def(k));
            end
            if (ns_a == 3'b001 && !prev_green) begin
                if (last_rise >= 0) begin
                    n_checks++;
                    if (k - last_rise != 16) begin
                        n_fail++;
                        $display("FAIL period at cycle %0d: got %0d expected 16", k, k - last_rise);
                    end
                end
                last_rise = k;
            end
            prev_green = (ns_a == 3'b001);
            @(negedge clk);
        end
    endtask

    task automatic test_min_params();
        rst_b = 1'b1;
        for (int k = 0; k < 13; k++) begin
            n_checks++;
            if ({ns_b, ew_b} !== exp_min(k)) begin
                n_fail++;
                $display("FAIL min cycle %0d: got %b/%b expected %b", k, ns_b, ew_b, exp_min(k));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal(input logic [2:0] code);
        @(negedge clk);
        force dut.r_state = state_t'(code);
        #1;
        n_checks++;
        if ({ns_a, ew_a} !== 6'b100_100) begin
            n_fail++;
            $display("FAIL illegal_%b: got %b/%b expected 100/100", code, ns_a, ew_a);
        end
        release dut.r_state;
        @(negedge clk);
        n_checks++;
        if ({ns_a, ew_a} !== 6'b100_100) begin
            n_fail++;
            $display("FAIL illegal_allred2: got %b/%b expected 100/100", ns_a, ew_a);
        end
        @(negedge clk);
        for (int k = 0; k <= 5; k++) begin
            n_checks++;
            if ({ns_a, ew_a} !== exp_def(k)) begin
                n_fail++;
                $display("FAIL illegal_recover cycle %0d: got %b/%b expected %b", k, ns_a, ew_a, exp_def(k));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_reset_mid();
        test_freerun();
        test_min_params();
        test_illegal(3'b111);
        test_illegal(3'b110);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
